aes128_round_seq: RTL and testbench
===================================

Name: aes128_round_seq

Overview:
- Hardware sequencer for the RV32IMV AES-128 vector datapath (vaddrk, vsubshift, vmixcolumns, vinvsubshift, vinvmixcolumns, vxor, vle32/vse32 on 128-bit blocks).
- Replaces the software key-schedule, encrypt and decrypt loops with an FSM.
- Issues one datapath micro-op per valid/ready handshake, and generates round-key addresses and round constants.
- Sits between the CPU's custom-instruction decode (start/mode) and the vector AES unit.

Parameters:
- NR, 10: number of AES rounds.
- RK_BASE, 32'h58: byte address of round key 0. Round key r is at RK_BASE+16*r.
- KEY_ADDR, 32'h48: initial key address.
- IN_ADDR, 32'h28: input block address.
- OUT_ADDR, 32'h38: output block address.

Ports:
- clk  in  1  clock.
- clrn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  2  operation select: 00 key schedule, 01 encrypt, 10 decrypt, 11 illegal.
- op_valid  out  1  micro-op presented.
- op_ready  in  1  datapath accepts the op this cycle.
- op_code  out  4  micro-op encoding (aes_seq_pkg).
- op_addr  out  32  memory byte address for LD/ST/XOR ops; 0 otherwise.
- op_rcon  out  8  round constant for ADDRK; 0 otherwise.
- round  out  4  current round index.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, for illegal mode.

Behaviour:
- Reset values: all outputs 0; state IDLE; rcon register 8'h01.
- Handshake:
  - An op transfers on a cycle with op_valid&&op_ready.
  - While op_valid&&!op_ready, op_code, op_addr and op_rcon hold stable.
  - op_valid never drops without a transfer.
  - The next op is presented the cycle after a transfer (zero bubble permitted; op_valid may stay high).
- Ops: LDKEY, LDIN, STRK, STOUT, ADDRK, XORRK, SUB, MIX, ISUB, IMIX.
- Key schedule, mode 00 (22 ops):
  - LDKEY@KEY_ADDR, STRK@RK_BASE.
  - Then for r=1..NR: ADDRK(rcon_r), STRK@RK_BASE+16r.
- Encrypt, mode 01 (32 ops):
  - LDIN@IN_ADDR, XORRK@rk0.
  - For r=1..NR-1: SUB, MIX, XORRK@rk_r.
  - SUB, XORRK@rk_NR, STOUT@OUT_ADDR.
- Decrypt, mode 10 (32 ops):
  - LDIN@OUT_ADDR, XORRK@rk_NR.
  - For r=NR-1 down to 1: ISUB, XORRK@rk_r, IMIX.
  - ISUB, XORRK@rk0, STOUT@OUT_ADDR.
- FSM states:
  - IDLE: on start, latch mode, go to LOAD. mode 11 goes straight to DONE with err.
  - LOAD.
  - KEY0.
  - MAIN_A, MAIN_B, MAIN_C: the three ops per round; a transfer on the last op advances round.
  - FIN_A, FIN_B: transitions occur when round reaches its terminal value.
  - STORE.
  - DONE: 1 cycle, done=1, then IDLE.
- Round counter:
  - 4 bits, incremented (enc/keysched) or decremented (dec) on the round's last transfer.
  - Address arithmetic: RK_BASE + {round,4'b0}, 32-bit, no wrap checking.
- Rcon:
  - Starts at 01; after each ADDRK transfer, rcon <= xtime(rcon) (shift left; xor 8'h1B if bit7 set).
  - Sequence: 01 02 04 08 10 20 40 80 1B 36.
  - Reset to 01 in IDLE.
- Boundary conditions:
  - start while busy: ignored.
  - start in DONE cycle: ignored.
  - op_ready high with op_valid low: ignored.
  - clrn asserted mid-operation: returns immediately to IDLE with all outputs 0. The datapath op in flight is abandoned; no done is generated.
- Latency with op_ready tied high: start to done = 1 + N_ops + 1 cycles (24 for keysched, 34 for enc/dec).

Decomposition:
- aes_seq_pkg holds:
  - op_code localparams (LDKEY=1, LDIN=2, STRK=3, STOUT=4, ADDRK=5, XORRK=6, SUB=7, MIX=8, ISUB=9, IMIX=10).
  - mode encodings.
  - FSM state encodings.
- One sub-module, aes_rcon_xtime: a combinational GF(2^8) xtime used for rcon update.

Test Plan:
- Key schedule, op_ready=1, mode=00 -> 22 ops. ADDRK rcon sequence is 01,02,04,08,10,20,40,80,1B,36. STRK addresses run 0x58..0xF8 in steps of 16. done at cycle 24; busy high for cycles 1..23.
- Encrypt, op_ready=1 -> first ops LDIN@0x28, XORRK@0x58. Last three ops SUB, XORRK@0xF8, STOUT@0x38. 32 ops total; done pulse exactly once.
- Decrypt with op_ready random 50% -> op fields stable during every stall. Order is ISUB, XORRK, IMIX per round, with XORRK addresses 0xE8 down to 0x68, then ISUB, XORRK@0x58, STOUT.
- Illegal mode 11 -> no op_valid; done=err=1 one cycle after start; busy stays 0.
- start pulsed at op #5 of encrypt -> ignored; op count unchanged.
- clrn low during MAIN_B of round 4 -> outputs 0 within the same cycle. After release, a new keysched runs from LDKEY with rcon 01.

Source files
------------

// File: rtl/aes_seq_pkg.sv
// Shared encodings for the AES-128 round sequencer.
//   - Micro-op codes presented on op_code to the vector AES datapath.
//   - Operation mode encodings carried on the mode input.
//   - Sequencer FSM state encoding.
package aes_seq_pkg;

  // Micro-op codes; 0 means "no op" and appears whenever op_valid is low.
  localparam logic [3:0] OpNone  = 4'd0;
  localparam logic [3:0] OpLdKey = 4'd1;
  localparam logic [3:0] OpLdIn  = 4'd2;
  localparam logic [3:0] OpStRk  = 4'd3;
  localparam logic [3:0] OpStOut = 4'd4;
  localparam logic [3:0] OpAddRk = 4'd5;
  localparam logic [3:0] OpXorRk = 4'd6;
  localparam logic [3:0] OpSub   = 4'd7;
  localparam logic [3:0] OpMix   = 4'd8;
  localparam logic [3:0] OpISub  = 4'd9;
  localparam logic [3:0] OpIMix  = 4'd10;

  // Operation modes.
  localparam logic [1:0] ModeKey     = 2'b00;
  localparam logic [1:0] ModeEnc     = 2'b01;
  localparam logic [1:0] ModeDec     = 2'b10;
  localparam logic [1:0] ModeIllegal = 2'b11;

  // StArm is a one-cycle slot between the accepted start and the first op.
  typedef enum logic [3:0] {
    StIdle,
    StArm,
    StLoad,
    StKey0,
    StMainA,
    StMainB,
    StMainC,
    StFinA,
    StFinB,
    StStore,
    StDone
  } state_e;

endpackage

// File: rtl/aes_rcon_xtime.sv
// GF(2^8) multiply-by-x (xtime) with the AES reduction polynomial, used to
// step the round constant.
//   a_i  : input byte
//   y_o  : a_i * x mod (x^8 + x^4 + x^3 + x + 1)
module aes_rcon_xtime (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  always_comb begin
    y_o = {a_i[6:0], 1'b0};
    if (a_i[7]) begin
      y_o = y_o ^ 8'h1B;
    end
  end

endmodule

// File: rtl/aes128_round_seq.sv
// AES-128 round sequencer. Replaces the software key-schedule, encrypt and
// decrypt loops: on start it walks the round structure and issues one
// micro-op per valid/ready handshake to the vector AES datapath, supplying
// round-key addresses and round constants.
//
// Ports:
//   clk_i       clock
//   clrn_i      asynchronous active-low reset
//   start_i     one-cycle request, sampled only when idle
//   mode_i      00 key schedule, 01 encrypt, 10 decrypt, 11 illegal
//   op_valid_o  micro-op presented
//   op_ready_i  datapath accepts the presented op this cycle
//   op_code_o   micro-op code (aes_seq_pkg)
//   op_addr_o   byte address for load/store/xor ops, 0 otherwise
//   op_rcon_o   round constant for ADDRK, 0 otherwise
//   round_o     current round index
//   busy_o      high from the cycle after an accepted start until done
//   done_o      one-cycle completion pulse
//   err_o       one-cycle pulse with done_o for an illegal mode
module aes128_round_seq
  import aes_seq_pkg::*;
#(
  parameter int unsigned NR       = 10,
  parameter logic [31:0] RK_BASE  = 32'h58,
  parameter logic [31:0] KEY_ADDR = 32'h48,
  parameter logic [31:0] IN_ADDR  = 32'h28,
  parameter logic [31:0] OUT_ADDR = 32'h38
) (
  input  logic        clk_i,
  input  logic        clrn_i,
  input  logic        start_i,
  input  logic [1:0]  mode_i,
  output logic        op_valid_o,
  input  logic        op_ready_i,
  output logic [3:0]  op_code_o,
  output logic [31:0] op_addr_o,
  output logic [7:0]  op_rcon_o,
  output logic [3:0]  round_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam logic [3:0] NrL = 4'(NR);

  state_e      state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [3:0]  round_q, round_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [7:0]  rcon_next;
  logic [31:0] rk_addr;
  logic        is_key, is_enc, is_dec;

  aes_rcon_xtime u_xtime (
    .a_i (rcon_q),
    .y_o (rcon_next)
  );

  assign is_key  = (mode_q == ModeKey);
  assign is_enc  = (mode_q == ModeEnc);
  assign is_dec  = (mode_q == ModeDec);
  assign rk_addr = RK_BASE + {24'd0, round_q, 4'd0};

  assign round_o = round_q;
  assign busy_o  = (state_q != StIdle) && (state_q != StDone);
  assign done_o  = (state_q == StDone);
  assign err_o   = (state_q == StDone) && (mode_q == ModeIllegal);

  // Op fields are a pure function of the registered state, so they cannot
  // change while a presented op is stalled.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    round_d    = round_q;
    rcon_d     = rcon_q;
    op_valid_o = 1'b0;
    op_code_o  = OpNone;
    op_addr_o  = '0;
    op_rcon_o  = '0;

    unique case (state_q)
      StIdle: begin
        rcon_d  = 8'h01;
        round_d = '0;
        if (start_i) begin
          mode_d = mode_i;
          if (mode_i == ModeIllegal) begin
            state_d = StDone;
          end else begin
            state_d = StArm;
            if (mode_i == ModeDec) begin
              round_d = NrL;
            end
          end
        end
      end

      StArm: begin
        state_d = StLoad;
      end

      StLoad: begin
        op_valid_o = 1'b1;
        op_code_o  = is_key ? OpLdKey : OpLdIn;
        op_addr_o  = is_key ? KEY_ADDR : (is_enc ? IN_ADDR : OUT_ADDR);
        if (op_ready_i) begin
          state_d = StKey0;
        end
      end

      // Initial round-key op: store rk0, or whiten with rk0 / rk_NR.
      StKey0: begin
        op_valid_o = 1'b1;
        op_code_o  = is_key ? OpStRk : OpXorRk;
        op_addr_o  = rk_addr;
        if (op_ready_i) begin
          round_d = is_dec ? round_q - 4'd1 : round_q + 4'd1;
          // With a single round the cipher has no full rounds to run.
          state_d = (!is_key && (NrL == 4'd1)) ? StFinA : StMainA;
        end
      end

      StMainA: begin
        op_valid_o = 1'b1;
        if (is_key) begin
          op_code_o = OpAddRk;
          op_rcon_o = rcon_q;
        end else begin
          op_code_o = is_enc ? OpSub : OpISub;
        end
        if (op_ready_i) begin
          state_d = StMainB;
          if (is_key) begin
            rcon_d = rcon_next;
          end
        end
      end

      StMainB: begin
        op_valid_o = 1'b1;
        if (is_key) begin
          op_code_o = OpStRk;
          op_addr_o = rk_addr;
        end else if (is_enc) begin
          op_code_o = OpMix;
        end else begin
          op_code_o = OpXorRk;
          op_addr_o = rk_addr;
        end
        if (op_ready_i) begin
          if (is_key) begin
            // Key schedule rounds are two ops; the last store ends the run.
            if (round_q == NrL) begin
              state_d = StDone;
            end else begin
              round_d = round_q + 4'd1;
              state_d = StMainA;
            end
          end else begin
            state_d = StMainC;
          end
        end
      end

      StMainC: begin
        op_valid_o = 1'b1;
        if (is_enc) begin
          op_code_o = OpXorRk;
          op_addr_o = rk_addr;
        end else begin
          op_code_o = OpIMix;
        end
        if (op_ready_i) begin
          if (is_enc) begin
            round_d = round_q + 4'd1;
            state_d = (round_q == NrL - 4'd1) ? StFinA : StMainA;
          end else begin
            round_d = round_q - 4'd1;
            state_d = (round_q == 4'd1) ? StFinA : StMainA;
          end
        end
      end

      StFinA: begin
        op_valid_o = 1'b1;
        op_code_o  = is_enc ? OpSub : OpISub;
        if (op_ready_i) begin
          state_d = StFinB;
        end
      end

      StFinB: begin
        op_valid_o = 1'b1;
        op_code_o  = OpXorRk;
        op_addr_o  = rk_addr;
        if (op_ready_i) begin
          state_d = StStore;
        end
      end

      StStore: begin
        op_valid_o = 1'b1;
        op_code_o  = OpStOut;
        op_addr_o  = OUT_ADDR;
        if (op_ready_i) begin
          state_d = StDone;
        end
      end

      StDone: begin
        round_d = '0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge clrn_i) begin
    if (!clrn_i) begin
      state_q <= StIdle;
      mode_q  <= ModeKey;
      round_q <= '0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

endmodule

// File: tb/tb_aes128_round_seq.sv
// Self-checking bench for aes128_round_seq: a table of runs plus random runs,
// each compared op-by-op against a reference op list built from the round
// structure of AES-128.
module tb_aes128_round_seq;

  localparam logic [3:0] CLdKey = 4'd1, CLdIn = 4'd2, CStRk = 4'd3, CStOut = 4'd4;
  localparam logic [3:0] CAddRk = 4'd5, CXorRk = 4'd6, CSub = 4'd7, CMix = 4'd8;
  localparam logic [3:0] CISub = 4'd9, CIMix = 4'd10;
  localparam int Nr = 10;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] addr;
    logic [7:0]  rcon;
  } op_t;

  typedef struct {
    logic [1:0]  mode;
    int unsigned pct;
    int          done_cyc;
    int          poke_at;
    bit          poke_done;
  } case_t;

  logic        clk = 1'b0;
  logic        clrn, start, op_ready, op_valid, busy, done, err;
  logic [1:0]  mode;
  logic [3:0]  op_code, round;
  logic [31:0] op_addr;
  logic [7:0]  op_rcon;

  int n_checks = 0;
  int n_fail = 0;
  op_t exp_q[$];

  always #5 clk = ~clk;

  aes128_round_seq dut (
    .clk_i      (clk),
    .clrn_i     (clrn),
    .start_i    (start),
    .mode_i     (mode),
    .op_valid_o (op_valid),
    .op_ready_i (op_ready),
    .op_code_o  (op_code),
    .op_addr_o  (op_addr),
    .op_rcon_o  (op_rcon),
    .round_o    (round),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rk(input int r);
    return 32'h58 + 32'(16 * r);
  endfunction

  function automatic void push_op(input logic [3:0] c, input logic [31:0] a, input logic [7:0] k);
    op_t o;
    o.code = c;
    o.addr = a;
    o.rcon = k;
    exp_q.push_back(o);
  endfunction

  // Reference op list, straight from the round structure of each mode.
  task automatic build_model(input logic [1:0] m);
    logic [7:0] rc_tab [10];
    rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    exp_q.delete();
    case (m)
      2'b00: begin
        push_op(CLdKey, 32'h48, 8'h00);
        push_op(CStRk, rk(0), 8'h00);
        for (int r = 1; r <= Nr; r++) begin
          push_op(CAddRk, 32'h0, rc_tab[r-1]);
          push_op(CStRk, rk(r), 8'h00);
        end
      end
      2'b01: begin
        push_op(CLdIn, 32'h28, 8'h00);
        push_op(CXorRk, rk(0), 8'h00);
        for (int r = 1; r < Nr; r++) begin
          push_op(CSub, 32'h0, 8'h00);
          push_op(CMix, 32'h0, 8'h00);
          push_op(CXorRk, rk(r), 8'h00);
        end
        push_op(CSub, 32'h0, 8'h00);
        push_op(CXorRk, rk(Nr), 8'h00);
        push_op(CStOut, 32'h38, 8'h00);
      end
      2'b10: begin
        push_op(CLdIn, 32'h38, 8'h00);
        push_op(CXorRk, rk(Nr), 8'h00);
        for (int r = Nr - 1; r >= 1; r--) begin
          push_op(CISub, 32'h0, 8'h00);
          push_op(CXorRk, rk(r), 8'h00);
          push_op(CIMix, 32'h0, 8'h00);
        end
        push_op(CISub, 32'h0, 8'h00);
        push_op(CXorRk, rk(0), 8'h00);
        push_op(CStOut, 32'h38, 8'h00);
      end
      default: ;
    endcase
  endtask

  // One complete run: start at cycle 0, observe each following cycle at the
  // falling edge, collect transfers, and compare against the model.
  task automatic run_case(input string tag, input logic [1:0] m, input int unsigned pct,
                          input int exp_done_cyc, input int poke_at, input bit poke_done);
    op_t got[$];
    op_t cur, held;
    int  cyc, done_cnt, err_cnt, busy_cnt, done_cyc, n;
    bit  stalled, poked, finished, idle_bad, rdy;
    build_model(m);
    cyc = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0; done_cyc = 0;
    stalled = 0; poked = 0; finished = 0; idle_bad = 0;
    @(negedge clk);
    start = 1'b1;
    mode = m;
    op_ready = 1'b0;
    while (!finished && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      mode = 2'($urandom_range(3));
      cur.code = op_code;
      cur.addr = op_addr;
      cur.rcon = op_rcon;
      if (stalled) begin
        check($sformatf("%s stall_valid c%0d", tag, cyc), 64'(op_valid), 64'(1));
        check($sformatf("%s stall_fields c%0d", tag, cyc), 64'(cur), 64'(held));
      end
      busy_cnt += int'(busy);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (poke_done) begin
          start = 1'b1;
          mode = 2'b01;
        end
      end
      if (err) err_cnt++;
      if (done_cnt > 0 && cyc > done_cyc && (busy || op_valid)) idle_bad = 1'b1;
      if (poke_at >= 0 && !poked && op_valid && got.size() == poke_at) begin
        start = 1'b1;
        mode = 2'b00;
        poked = 1'b1;
      end
      rdy = ($urandom_range(99) < pct);
      op_ready = rdy;
      stalled = op_valid && !rdy;
      held = cur;
      if (op_valid && rdy) got.push_back(cur);
      if (done_cnt > 0 && cyc == done_cyc + 2) finished = 1'b1;
    end
    op_ready = 1'b0;
    check($sformatf("%s timeout", tag), 64'(finished), 64'(1));
    check($sformatf("%s op_count", tag), 64'(got.size()), 64'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s op%0d {code,addr,rcon}", tag, i), 64'(got[i]), 64'(exp_q[i]));
    end
    check($sformatf("%s done_pulses", tag), 64'(done_cnt), 64'(1));
    check($sformatf("%s err_pulses", tag), 64'(err_cnt), 64'((m == 2'b11) ? 1 : 0));
    check($sformatf("%s busy_cycles", tag), 64'(busy_cnt),
          64'((m == 2'b11) ? 0 : done_cyc - 1));
    check($sformatf("%s idle_after_done", tag), 64'(idle_bad), 64'(0));
    if (exp_done_cyc > 0) begin
      check($sformatf("%s done_cycle", tag), 64'(done_cyc), 64'(exp_done_cyc));
    end
  endtask

  // Reset asserted while encrypt presents MIX of round 4 (op index 12).
  task automatic reset_mid_test();
    int  n, cyc;
    bit  hit;
    n = 0; cyc = 0; hit = 0;
    @(negedge clk);
    start = 1'b1;
    mode = 2'b01;
    op_ready = 1'b1;
    while (!hit && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (op_valid && n == 12) begin
        hit = 1'b1;
      end else if (op_valid) begin
        n++;
      end
    end
    check("rst_mid reached", 64'(hit), 64'(1));
    check("rst_mid pre_code", 64'(op_code), 64'(CMix));
    clrn = 1'b0;
    #1;
    check("rst_mid outputs", 64'({op_valid, op_code, op_addr, op_rcon, round, busy, done, err}),
          64'(0));
    repeat (2) begin
      @(negedge clk);
      check("rst_mid held_outputs", 64'({op_valid, busy, done, err}), 64'(0));
    end
    clrn = 1'b1;
    op_ready = 1'b0;
    @(negedge clk);
    check("rst_mid no_done", 64'({done, busy}), 64'(0));
    run_case("post_reset_key", 2'b00, 100, 24, -1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    case_t tab[8];
    logic [1:0] m;
    int unsigned pct;
    tab[0] = '{2'b00, 100, 24, -1, 1'b0};
    tab[1] = '{2'b01, 100, 34, -1, 1'b0};
    tab[2] = '{2'b10, 100, 34, -1, 1'b0};
    tab[3] = '{2'b10, 50, 0, -1, 1'b0};
    tab[4] = '{2'b11, 100, 1, -1, 1'b0};
    tab[5] = '{2'b01, 100, 34, 5, 1'b0};
    tab[6] = '{2'b00, 100, 24, -1, 1'b1};
    tab[7] = '{2'b00, 40, 0, -1, 1'b0};

    clrn = 1'b0;
    start = 1'b0;
    mode = 2'b00;
    op_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset op_valid", 64'(op_valid), 64'(0));
    check("reset op_code", 64'(op_code), 64'(0));
    check("reset op_addr", 64'(op_addr), 64'(0));
    check("reset op_rcon", 64'(op_rcon), 64'(0));
    check("reset round", 64'(round), 64'(0));
    check("reset busy/done/err", 64'({busy, done, err}), 64'(0));
    clrn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_case($sformatf("tab%0d", i), tab[i].mode, tab[i].pct, tab[i].done_cyc,
               tab[i].poke_at, tab[i].poke_done);
    end

    for (int i = 0; i < 6; i++) begin
      m = 2'($urandom_range(2));
      pct = $urandom_range(20, 100);
      run_case($sformatf("rnd%0d", i), m, pct, (pct == 100) ? ((m == 2'b00) ? 24 : 34) : 0,
               -1, 1'b0);
    end

    reset_mid_test();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
